// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI note receiver: status nibbles,
// parser running-status and UART state encodings.
package midi_pkg;

  localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
  localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
  localparam logic [6:0] DEFAULT_NOTE = 7'd69;

  typedef enum logic [1:0] {
    RS_NONE,
    RS_NOTE_OFF,
    RS_NOTE_ON,
    RS_OTHER
  } run_status_e;

  typedef enum logic [2:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP,
    U_WAIT_IDLE
  } uart_state_e;

  // System realtime bytes (0xF8-0xFF) may appear anywhere, even mid-message.
  function automatic logic is_realtime(input logic [7:0] b);
    return b[7:3] == 5'b11111;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver for the MIDI input: 2-flop synchroniser, mid-bit
// sampling, glitch rejection on the start bit and framing-error reporting.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_framing_error
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;

  uart_state_e   r_state;
  logic [1:0]    r_sync;
  logic          r_rx_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_byte_valid;
  logic          r_ferr;
  logic          w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync       <= 2'b11;
      r_rx_prev    <= 1'b1;
      r_state      <= U_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_ferr       <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], i_rx};
      r_rx_prev    <= w_rx;
      r_byte_valid <= 1'b0;
      r_ferr       <= 1'b0;
      unique case (r_state)
        U_IDLE: begin
          r_cnt <= '0;
          if (r_rx_prev && !w_rx) r_state <= U_START;
        end
        U_START: begin
          if (r_cnt == CW'(HALF - 1)) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            // Line back high at mid start bit: treat as noise, no byte.
            r_state <= w_rx ? U_IDLE : U_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= U_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_byte_valid <= 1'b1;
              r_state      <= U_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= U_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_WAIT_IDLE: begin
          if (w_rx) r_state <= U_IDLE;
        end
        default: r_state <= U_IDLE;
      endcase
    end
  end

  assign o_byte          = r_shift;
  assign o_byte_valid    = r_byte_valid;
  assign o_framing_error = r_ferr;

endmodule

// File: rtl/midi_note_receiver.sv
// MIDI Note On/Off front end for the tone generator: running-status parser
// driving a monophonic, last-note-priority note/velocity/gate output.
module midi_note_receiver
  import midi_pkg::*;
#(
  parameter int         CLK_HZ            = 50000000,
  parameter int         BAUD              = 31250,
  parameter bit         CHANNEL_FILTER_EN = 1'b0,
  parameter logic [3:0] CHANNEL           = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic [6:0] MIDI_freq,
  output logic [6:0] volume,
  output logic       gate,
  output logic       note_strobe,
  output logic       framing_error
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic [7:0]  w_byte;
  logic        w_byte_valid;
  logic        w_ferr;
  logic        w_chan_ok;
  logic [6:0]  w_data;

  run_status_e r_rs;
  logic        r_idx;
  logic [6:0]  r_key;
  logic [6:0]  r_freq;
  logic [6:0]  r_vol;
  logic        r_gate;
  logic        r_strobe;

  midi_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk          (clk),
    .i_rst          (reset),
    .i_rx           (midi_rx),
    .o_byte         (w_byte),
    .o_byte_valid   (w_byte_valid),
    .o_framing_error(w_ferr)
  );

  assign w_chan_ok = !CHANNEL_FILTER_EN || (w_byte[3:0] == CHANNEL);
  assign w_data    = w_byte[6:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rs     <= RS_NONE;
      r_idx    <= 1'b0;
      r_key    <= '0;
      r_freq   <= DEFAULT_NOTE;
      r_vol    <= '0;
      r_gate   <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_byte_valid) begin
        if (is_realtime(w_byte)) begin
          // Realtime bytes are transparent to message assembly.
        end else if (w_byte[7:4] == 4'hF) begin
          r_rs  <= RS_NONE;
          r_idx <= 1'b0;
        end else if (w_byte[7]) begin
          r_idx <= 1'b0;
          if (w_chan_ok && w_byte[7:4] == NIB_NOTE_OFF)     r_rs <= RS_NOTE_OFF;
          else if (w_chan_ok && w_byte[7:4] == NIB_NOTE_ON) r_rs <= RS_NOTE_ON;
          else                                              r_rs <= RS_OTHER;
        end else if (r_rs == RS_NOTE_ON || r_rs == RS_NOTE_OFF) begin
          if (!r_idx) begin
            r_key <= w_data;
            r_idx <= 1'b1;
          end else begin
            r_idx <= 1'b0;
            if (r_rs == RS_NOTE_ON && w_data != 7'd0) begin
              r_freq   <= r_key;
              r_vol    <= w_data;
              r_gate   <= 1'b1;
              r_strobe <= 1'b1;
            end else if (r_gate && r_key == r_freq) begin
              // Only releasing the sounding key silences; MIDI_freq is kept.
              r_gate <= 1'b0;
              r_vol  <= '0;
            end
          end
        end
      end
    end
  end

  assign MIDI_freq     = r_freq;
  assign volume        = r_vol;
  assign gate          = r_gate;
  assign note_strobe   = r_strobe;
  assign framing_error = w_ferr;

endmodule

// File: tb/tb_midi_note_receiver.sv
// Directed bench for midi_note_receiver: an omni instance and a channel-2
// filtered instance share one serial line, checked against a message model.
module tb_midi_note_receiver;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 31250;
  localparam int CPB    = CLK_HZ / BAUD;

  logic clk = 1'b0, reset = 1'b1, midi_rx = 1'b1;
  logic [6:0] f0, v0, f1, v1;
  logic g0, s0, e0, g1, s1, e1;

  midi_note_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .midi_rx(midi_rx), .MIDI_freq(f0), .volume(v0),
    .gate(g0), .note_strobe(s0), .framing_error(e0));

  midi_note_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL_FILTER_EN(1'b1),
                       .CHANNEL(4'd2)) dutf (
    .clk(clk), .reset(reset), .midi_rx(midi_rx), .MIDI_freq(f1), .volume(v1),
    .gate(g1), .note_strobe(s1), .framing_error(e1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  bit settled = 0;
  int t0, strb_cyc0;

  // Model: mode 0 = no note message open, 1 = note off, 2 = note on
  int m_freq[2], m_vol[2], m_gate[2], m_strb[2], m_mode[2], m_haskey[2], m_key[2];
  int m_ferr;
  int a_strb[2], a_ferr[2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad < 30) $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_freq[d] = 69; m_vol[d] = 0; m_gate[d] = 0;
      m_mode[d] = 0; m_haskey[d] = 0; m_key[d] = 0;
    end
  endtask

  task automatic model_byte(input int d, input logic [7:0] b);
    int hi, ch, vel;
    hi = int'(b) / 16;
    ch = int'(b) % 16;
    if (b >= 8'hF8) return;
    if (b >= 8'h80) begin
      m_haskey[d] = 0;
      if ((hi == 8 || hi == 9) && (d == 0 || ch == 2)) m_mode[d] = (hi == 9) ? 2 : 1;
      else m_mode[d] = 0;
      return;
    end
    if (m_mode[d] == 0) return;
    if (!m_haskey[d]) begin
      m_key[d] = int'(b); m_haskey[d] = 1;
      return;
    end
    m_haskey[d] = 0;
    vel = int'(b);
    if (m_mode[d] == 2 && vel > 0) begin
      m_freq[d] = m_key[d]; m_vol[d] = vel; m_gate[d] = 1; m_strb[d]++;
    end else if (m_gate[d] == 1 && m_key[d] == m_freq[d]) begin
      m_gate[d] = 0; m_vol[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (s0) begin a_strb[0]++; strb_cyc0 = cyc; end
    if (s1) a_strb[1]++;
    if (e0) a_ferr[0]++;
    if (e1) a_ferr[1]++;
    if (settled && !reset) begin
      chk("freq0", int'(f0), m_freq[0]);   chk("vol0", int'(v0), m_vol[0]);
      chk("gate0", int'(g0), m_gate[0]);   chk("strobes0", a_strb[0], m_strb[0]);
      chk("freq1", int'(f1), m_freq[1]);   chk("vol1", int'(v1), m_vol[1]);
      chk("gate1", int'(g1), m_gate[1]);   chk("strobes1", a_strb[1], m_strb[1]);
      chk("ferr0", a_ferr[0], m_ferr);     chk("ferr1", a_ferr[1], m_ferr);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    settled = 0;
    @(posedge clk); #1;
    t0 = cyc;
    midi_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk); #1;
      midi_rx = b[i];
    end
    repeat (CPB) @(posedge clk); #1;
    midi_rx = stop_ok;
    repeat (CPB) @(posedge clk); #1;
    midi_rx = 1'b1;
    if (stop_ok) begin
      model_byte(0, b);
      model_byte(1, b);
    end else begin
      m_ferr++;
    end
    repeat (4) @(posedge clk);
    settled = 1;
    repeat (CPB / 2) @(posedge clk);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a, 1); send_byte(b, 1); send_byte(c, 1);
  endtask

  initial begin
    model_reset();
    m_strb[0] = 0; m_strb[1] = 0; m_ferr = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_freq0", int'(f0), 69); chk("rst_vol0", int'(v0), 0);
    chk("rst_gate0", int'(g0), 0);  chk("rst_strb0", int'(s0), 0);
    chk("rst_ferr0", int'(e0), 0);  chk("rst_freq1", int'(f1), 69);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    settled = 1;

    // 1: basic note on, with exact output latency
    send3(8'h90, 8'h3C, 8'h64);
    chk("latency", strb_cyc0 - t0, 308);
    chk("s1_freq", int'(f0), 60); chk("s1_vol", int'(v0), 100);
    chk("s1_gate", int'(g0), 1);  chk("s1_strb", a_strb[0], 1);
    chk("s1_filt_freq", int'(f1), 69);

    // 2: running status continues the note-on stream
    send_byte(8'h40, 1); send_byte(8'h50, 1);
    chk("s2_freq", int'(f0), 64); chk("s2_vol", int'(v0), 80);
    chk("s2_strb", a_strb[0], 2);

    // 3: releasing a non-sounding key does nothing; velocity-0 on releases
    send3(8'h90, 8'h3C, 8'h64);
    send3(8'h80, 8'h3E, 8'h00);
    chk("s3_keep_gate", int'(g0), 1); chk("s3_keep_vol", int'(v0), 100);
    send3(8'h90, 8'h3C, 8'h00);
    chk("s3_gate", int'(g0), 0); chk("s3_vol", int'(v0), 0);
    chk("s3_freq", int'(f0), 60);

    // 4: realtime bytes interleaved, then sysex cancels running status
    send_byte(8'h90, 1); send_byte(8'hF8, 1); send_byte(8'h3C, 1);
    send_byte(8'hFE, 1); send_byte(8'h64, 1);
    chk("s4_freq", int'(f0), 60); chk("s4_vol", int'(v0), 100);
    chk("s4_strb", a_strb[0], 4);
    send3(8'hF0, 8'h3E, 8'h70);
    chk("s4_sysex_freq", int'(f0), 60); chk("s4_sysex_strb", a_strb[0], 4);

    // 5: framing error, then a short start glitch, then a clean message
    send_byte(8'h55, 0);
    chk("s5_ferr", a_ferr[0], 1); chk("s5_freq", int'(f0), 60);
    settled = 0;
    @(posedge clk); #1;
    midi_rx = 1'b0;
    repeat (CPB / 4) @(posedge clk); #1;
    midi_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    settled = 1;
    chk("s5_glitch_ferr", a_ferr[0], 1);
    send3(8'h90, 8'h40, 8'h20);
    chk("s5_after_freq", int'(f0), 64); chk("s5_after_vol", int'(v0), 32);

    // 6: channel filter, then reset in the middle of a data byte
    send3(8'h91, 8'h3C, 8'h64);
    chk("s6_rej_freq", int'(f1), 69); chk("s6_rej_gate", int'(g1), 0);
    send3(8'h92, 8'h3C, 8'h64);
    chk("s6_acc_freq", int'(f1), 60); chk("s6_acc_vol", int'(v1), 100);
    settled = 0;
    @(posedge clk); #1;
    midi_rx = 1'b0;
    repeat (3 * CPB) @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("s6_rst_freq0", int'(f0), 69); chk("s6_rst_gate0", int'(g0), 0);
    chk("s6_rst_vol1", int'(v1), 0);   chk("s6_rst_freq1", int'(f1), 69);
    midi_rx = 1'b1;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    repeat (2 * CPB) @(posedge clk);
    settled = 1;
    send3(8'h92, 8'h3E, 8'h70);
    chk("s6_post_freq0", int'(f0), 62); chk("s6_post_freq1", int'(f1), 62);
    chk("s6_post_vol1", int'(v1), 112);

    settled = 0;
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
